dbg_access_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single core debug access bus behind the JTAG debug access port. Requester 0 is the JTAG debug port and requester 1 is a secondary debug master, such as a self-hosted or system bus debugger. The block shares the bus with round-robin priority and optional lock (burst) hold. It issues one transaction at a time, routes the response back to its owner, and aborts transactions whose response does not arrive within a bounded window. It runs in the test-clock domain, between the requester ports and the core debug register target.

---
 rtl/dbg_access_arbiter.sv | 171 +++++++++++++++++
 tb/tb_dbg_access_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_access_arbiter.sv
// Two-requester arbiter and sequencer for the core debug access bus.
// Round-robin between the JTAG debug port (rq0) and a secondary debug master
// (rq1). A lock hold keeps the grant with the owner. Only one transaction is
// outstanding at a time, and any transaction whose response does not arrive
// within TIMEOUT cycles is aborted.
module dbg_access_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_write,
  input  logic              rq0_lock,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_write,
  input  logic              rq1_lock,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rs0_valid,
  output logic [DATA_W-1:0] rs0_rdata,
  output logic              rs0_err,
  output logic              rs1_valid,
  output logic [DATA_W-1:0] rs1_rdata,
  output logic              rs1_err,
  output logic              tgt_req_valid,
  input  logic              tgt_req_ready,
  output logic              tgt_req_write,
  output logic [ADDR_W-1:0] tgt_req_addr,
  output logic [DATA_W-1:0] tgt_req_wdata,
  input  logic              tgt_rsp_valid,
  input  logic [DATA_W-1:0] tgt_rsp_rdata,
  input  logic              tgt_rsp_err,
  output logic              tgt_abort,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                owner_q;
  logic                last_grant_q;
  logic                lock_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                hold_write_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic                elig0, elig1;
  logic                gnt0, gnt1;
  logic                accept;
  logic                timeout_hit;

  // Read data reaches a requester only for successful reads.
  function automatic logic [DATA_W-1:0] rsp_data_filter(input logic               wr,
                                                        input logic               err,
                                                        input logic [DATA_W-1:0]  d);
    return (wr || err) ? '0 : d;
  endfunction

  // While the lock is held, only the owner may compete. On a tie, the requester
  // that did not win last time gets the grant. Readies are suppressed during
  // reset so that every output reads 0 immediately.
  assign elig0  = rq0_valid & (~lock_q | ~owner_q);
  assign elig1  = rq1_valid & (~lock_q |  owner_q);
  assign gnt0   = (state_q == IDLE) & trst & elig0 & (~elig1 |  last_grant_q);
  assign gnt1   = (state_q == IDLE) & trst & elig1 & (~elig0 | ~last_grant_q);
  assign accept = gnt0 | gnt1;

  // A response in the same cycle as the deadline takes precedence over the abort.
  assign timeout_hit = (state_q == WAIT) & ~tgt_rsp_valid & TO_EN & (cnt_q == TO_LAST);

  assign rq0_ready     = gnt0;
  assign rq1_ready     = gnt1;
  assign tgt_req_valid = (state_q == ISSUE);
  assign tgt_req_write = hold_write_q;
  assign tgt_req_addr  = hold_addr_q;
  assign tgt_req_wdata = hold_wdata_q;
  assign tgt_abort     = timeout_hit;
  assign busy          = (state_q != IDLE);
  assign rs0_valid     = (state_q == RESP) & ~owner_q;
  assign rs1_valid     = (state_q == RESP) &  owner_q;
  assign rs0_rdata     = rs0_valid ? rsp_rdata_q : '0;
  assign rs1_rdata     = rs1_valid ? rsp_rdata_q : '0;
  assign rs0_err       = rs0_valid & rsp_err_q;
  assign rs1_err       = rs1_valid & rsp_err_q;

  // Next-state selection for the single outstanding transaction.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   if (tgt_req_ready) state_d = WAIT;
      WAIT:    if (tgt_rsp_valid || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register. A reset discards any outstanding transaction silently.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Ownership, round-robin history, lock hold and the response window counter.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (accept) begin
        owner_q      <= gnt1;
        last_grant_q <= gnt1;
        lock_q       <= gnt1 ? rq1_lock : rq0_lock;
      end else if (timeout_hit) begin
        lock_q <= 1'b0;
      end
      if (state_q == ISSUE && tgt_req_ready) cnt_q <= '0;
      else if (state_q == WAIT)              cnt_q <= cnt_q + 1'b1;
    end
  end

  // Holding registers for the accepted request. They stay stable through ISSUE.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      hold_write_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
    end else if (accept) begin
      hold_write_q <= gnt1 ? rq1_write : rq0_write;
      hold_addr_q  <= gnt1 ? rq1_addr  : rq0_addr;
      hold_wdata_q <= gnt1 ? rq1_wdata : rq0_wdata;
    end
  end

  // Response capture. A timeout is reported as an error with no data.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (state_q == WAIT) begin
      if (tgt_rsp_valid) begin
        rsp_rdata_q <= rsp_data_filter(hold_write_q, tgt_rsp_err, tgt_rsp_rdata);
        rsp_err_q   <= tgt_rsp_err;
      end else if (timeout_hit) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dbg_access_arbiter.sv
// Self-checking bench for dbg_access_arbiter: directed scenarios followed by
// randomized transactions, checked against a transaction-level reference model.
module tb_dbg_access_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TO     = 4;

  logic              tck = 1'b0;
  logic              trst;
  logic              rq0_valid, rq0_ready, rq0_write, rq0_lock;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq1_valid, rq1_ready, rq1_write, rq1_lock;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rs0_valid, rs0_err, rs1_valid, rs1_err;
  logic [DATA_W-1:0] rs0_rdata, rs1_rdata;
  logic              tgt_req_valid, tgt_req_ready, tgt_req_write;
  logic [ADDR_W-1:0] tgt_req_addr;
  logic [DATA_W-1:0] tgt_req_wdata;
  logic              tgt_rsp_valid, tgt_rsp_err;
  logic [DATA_W-1:0] tgt_rsp_rdata;
  logic              tgt_abort, busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state: who won last, who owns the bus, and whether the lock is held.
  int m_last  = 1;
  int m_owner = 0;
  bit m_lock  = 1'b0;

  dbg_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO), .CNT_W(8)) dut (
    .tck(tck), .trst(trst),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_write(rq0_write), .rq0_lock(rq0_lock),
    .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_write(rq1_write), .rq1_lock(rq1_lock),
    .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rs0_valid(rs0_valid), .rs0_rdata(rs0_rdata), .rs0_err(rs0_err),
    .rs1_valid(rs1_valid), .rs1_rdata(rs1_rdata), .rs1_err(rs1_err),
    .tgt_req_valid(tgt_req_valid), .tgt_req_ready(tgt_req_ready), .tgt_req_write(tgt_req_write),
    .tgt_req_addr(tgt_req_addr), .tgt_req_wdata(tgt_req_wdata),
    .tgt_rsp_valid(tgt_rsp_valid), .tgt_rsp_rdata(tgt_rsp_rdata), .tgt_rsp_err(tgt_rsp_err),
    .tgt_abort(tgt_abort), .busy(busy)
  );

  always #5 tck = ~tck;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (passed %0d of %0d)", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Spec-level winner rule: the eligible set is masked to the owner while the
  // lock is held; on a tie the requester that did not win last time wins.
  function automatic int model_winner(input bit v0, input bit v1, input bit lk,
                                      input int own, input int last);
    bit e0, e1;
    e0 = v0 && (!lk || own == 0);
    e1 = v1 && (!lk || own == 1);
    if (e0 && e1) return (last == 0) ? 1 : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // One complete transaction. Call at 1 time unit after a rising edge, with the DUT in IDLE.
  // rsp_cyc: the WAIT cycle (1-based) in which the target answers; > TO means never.
  task automatic txn(input bit v0, input bit v1, input bit l0, input bit l1,
                     input bit w0, input bit w1,
                     input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                     input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                     input int rdy_dly, input int rsp_cyc,
                     input logic [DATA_W-1:0] rsp_d, input bit rsp_e, input bit late,
                     output int win);
    bit                ew, el, timed_out, done, exp_abort;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed, exp_rdata;
    rq0_valid = v0; rq0_lock = l0; rq0_write = w0; rq0_addr = a0; rq0_wdata = d0;
    rq1_valid = v1; rq1_lock = l1; rq1_write = w1; rq1_addr = a1; rq1_wdata = d1;
    #1;
    win = model_winner(v0, v1, m_lock, m_owner, m_last);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("rq0_ready", 64'(rq0_ready), 64'(win == 0));
    chk("rq1_ready", 64'(rq1_ready), 64'(win == 1));
    if (win < 0) return;
    ew = (win == 1) ? w1 : w0;
    el = (win == 1) ? l1 : l0;
    ea = (win == 1) ? a1 : a0;
    ed = (win == 1) ? d1 : d0;
    m_last = win; m_owner = win; m_lock = el;
    @(posedge tck); #1;
    for (int i = 0; i <= rdy_dly; i++) begin
      tgt_req_ready = (i == rdy_dly);
      #1;
      chk("issue_valid", 64'(tgt_req_valid), 64'(1));
      chk("issue_write", 64'(tgt_req_write), 64'(ew));
      chk("issue_addr",  64'(tgt_req_addr),  64'(ea));
      chk("issue_wdata", 64'(tgt_req_wdata), 64'(ed));
      chk("issue_ready_low", 64'({rq0_ready, rq1_ready}), 64'(0));
      chk("issue_abort", 64'(tgt_abort), 64'(0));
      @(posedge tck); #1;
    end
    tgt_req_ready = 1'b0;
    done = 1'b0; timed_out = 1'b0;
    for (int k = 1; k <= TO + 2 && !done; k++) begin
      tgt_rsp_valid = (k == rsp_cyc);
      tgt_rsp_rdata = rsp_d;
      tgt_rsp_err   = rsp_e;
      #1;
      exp_abort = (k != rsp_cyc) && (k == TO);
      chk("wait_abort", 64'(tgt_abort), 64'(exp_abort));
      chk("wait_req_valid", 64'(tgt_req_valid), 64'(0));
      chk("wait_rs_low", 64'({rs0_valid, rs1_valid}), 64'(0));
      if (k == rsp_cyc || exp_abort) begin
        done = 1'b1;
        timed_out = exp_abort;
      end
      @(posedge tck); #1;
    end
    tgt_rsp_valid = late;
    tgt_rsp_rdata = 32'hBAD0_CAFE;
    tgt_rsp_err   = 1'b0;
    #1;
    exp_rdata = (timed_out || ew || rsp_e) ? '0 : rsp_d;
    chk("rs0_valid", 64'(rs0_valid), 64'(win == 0));
    chk("rs1_valid", 64'(rs1_valid), 64'(win == 1));
    chk("rs_rdata", 64'((win == 1) ? rs1_rdata : rs0_rdata), 64'(exp_rdata));
    chk("rs_err",   64'((win == 1) ? rs1_err : rs0_err), 64'(timed_out || rsp_e));
    chk("resp_ready_low", 64'({rq0_ready, rq1_ready}), 64'(0));
    if (timed_out) m_lock = 1'b0;
    @(posedge tck); #1;
    tgt_rsp_valid = 1'b0;
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_rs_low", 64'({rs0_valid, rs1_valid}), 64'(0));
  endtask

  initial begin
    int w, prev;
    bit rv0, rv1, rl0, rl1, rw0, rw1, rlate, rerr;
    int rdy, rspc;
    trst = 1'b0;
    rq0_valid = 0; rq0_write = 0; rq0_lock = 0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 0; rq1_write = 0; rq1_lock = 0; rq1_addr = '0; rq1_wdata = '0;
    tgt_req_ready = 0; tgt_rsp_valid = 0; tgt_rsp_rdata = '0; tgt_rsp_err = 0;

    // Reset values
    repeat (3) @(posedge tck);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_outs", 64'({rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs0_err, rs1_err,
                         tgt_req_valid, tgt_req_write, tgt_abort}), 64'(0));
    chk("rst_addr", 64'(tgt_req_addr), 64'(0));
    chk("rst_wdata", 64'(tgt_req_wdata), 64'(0));
    chk("rst_rdata", 64'({rs0_rdata, rs1_rdata}), 64'(0));
    trst = 1'b1;

    // Single read from rq0
    txn(1, 0, 0, 0, 0, 0, 8'h10, 8'h00, 32'h0, 32'h0, 0, 3, 32'hDEADBEEF, 0, 0, w);
    chk("single_winner", 64'(w), 64'(0));

    // Both valid continuously: grants alternate
    prev = 0;
    for (int n = 0; n < 8; n++) begin
      txn(1, 1, 0, 0, n[0], ~n[0], 8'(n), 8'(n + 8'h40), 32'(n * 3), 32'(n * 5),
          n % 2, 1 + (n % 3), 32'h1000 + 32'(n), 0, 0, w);
      chk("alt_grant", 64'(w), 64'(prev == 0 ? 1 : 0));
      prev = w;
    end

    // Lock burst from rq1 while rq0 stays valid
    txn(1, 0, 0, 0, 0, 0, 8'h01, 8'h00, 32'h0, 32'h0, 0, 1, 32'h5, 0, 0, w);
    for (int n = 0; n < 3; n++) begin
      txn(1, 1, 0, (n < 2), 0, 1, 8'h22, 8'h30 + 8'(n), 32'h0, 32'hA5A5_0000 + 32'(n),
          0, 2, 32'hFFFF_FFFF, 0, 0, w);
      chk("lock_burst_rq1", 64'(w), 64'(1));
    end
    txn(1, 1, 0, 0, 0, 0, 8'h23, 8'h33, 32'h0, 32'h0, 0, 1, 32'h77, 0, 0, w);
    chk("lock_release_rq0", 64'(w), 64'(0));

    // Timeout with lock held, late response, then the lock must be gone
    txn(1, 0, 1, 0, 0, 0, 8'h44, 8'h00, 32'h0, 32'h0, 1, TO + 5, 32'h0, 0, 1, w);
    txn(0, 1, 0, 0, 0, 0, 8'h00, 8'h45, 32'h0, 32'h0, 0, 1, 32'hC0DE, 0, 0, w);
    chk("after_timeout_rq1", 64'(w), 64'(1));

    // Target error on a read, stalled request, and a response at the deadline
    txn(1, 0, 0, 0, 0, 0, 8'h50, 8'h00, 32'h0, 32'h0, 0, 1, 32'h1234, 1, 0, w);
    txn(1, 0, 0, 0, 1, 0, 8'h51, 8'h00, 32'h99, 32'h0, 5, 1, 32'h0, 0, 0, w);
    txn(0, 1, 0, 0, 0, 0, 8'h00, 8'h52, 32'h0, 32'h0, 0, TO, 32'h600D, 0, 0, w);

    // Reset in WAIT with rq0 locked
    rq0_valid = 1; rq0_lock = 1; rq0_write = 0; rq0_addr = 8'h60; rq1_valid = 0;
    @(posedge tck); #1;
    tgt_req_ready = 1;
    @(posedge tck); #1;
    tgt_req_ready = 0;
    chk("pre_rst_busy", 64'(busy), 64'(1));
    trst = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_outs", 64'({rq0_ready, rq1_ready, rs0_valid, rs1_valid, tgt_req_valid, tgt_abort}), 64'(0));
    chk("mid_rst_addr", 64'(tgt_req_addr), 64'(0));
    repeat (2) begin
      @(posedge tck); #1;
      chk("mid_rst_no_rs", 64'({rs0_valid, rs1_valid}), 64'(0));
    end
    m_last = 1; m_lock = 1'b0; m_owner = 0;
    trst = 1'b1;
    txn(1, 1, 0, 0, 0, 0, 8'h70, 8'h71, 32'h0, 32'h0, 0, 1, 32'h4242, 0, 0, w);
    chk("post_rst_first", 64'(w), 64'(0));

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      rv0 = 1'($urandom_range(0, 1)); rv1 = 1'($urandom_range(0, 1));
      if (!rv0 && !rv1) rv0 = 1'b1;
      if (m_lock) begin
        if (m_owner == 0) rv0 = 1'b1; else rv1 = 1'b1;
      end
      rl0 = 1'($urandom_range(0, 1)); rl1 = 1'($urandom_range(0, 1));
      rw0 = 1'($urandom_range(0, 1)); rw1 = 1'($urandom_range(0, 1));
      rlate = 1'($urandom_range(0, 1)); rerr = ($urandom_range(0, 3) == 0);
      rdy = int'($urandom_range(0, 3)); rspc = int'($urandom_range(1, TO + 1));
      txn(rv0, rv1, rl0, rl1, rw0, rw1, 8'($urandom), 8'($urandom), $urandom, $urandom,
          rdy, rspc, $urandom, rerr, rlate, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
